gate_response_checker: RTL

- Response-side counterpart to our gate testbench stimulus sequences: the stimulus side drives {a,b} vectors into a 2-input gate; this block receives each applied vector plus the DUT output and checks it.
- Checks each vector against a parameterised truth table after a settle delay.
- Counts checks and errors, tracks input-combination coverage and reports a single pass/fail verdict.
- Synthesisable, so it can sit beside any 2-input gate model in simulation or on hardware.

---
 rtl/gate_response_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gate_response_checker.sv
// Response checker for a 2-input gate under test.
// Each accepted {a,b} vector is held while the gate output settles. The gate
// output is then compared against the GATE_FUNC truth table. Checks, errors and
// input coverage are accumulated until the run is stopped. A single verdict is
// then held until the next start.
//
// state | meaning
// IDLE  | out of reset, waiting for the first start
// RUN   | ready to accept a vector
// WAIT  | vector accepted, counting down to the dut_c sample point
// DONE  | verdict valid and held until the next start
module gate_response_checker #(
    parameter logic [3:0] GATE_FUNC = 4'b1000,
    parameter int         SETTLE    = 2,
    parameter int         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             vec_valid,
    input  logic             vec_a,
    input  logic             vec_b,
    input  logic             dut_c,
    output logic             vec_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // The counter loads SETTLE-1 and samples when it reads zero.
    // This places the sample on the SETTLE-th edge after acceptance.
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [3:0]       settle_cnt;
    logic [1:0]       vec_lat;
    logic             stop_pend;

    logic             accept;
    logic             sample;
    logic             mismatch;
    logic             clear;
    logic             enter_done;
    logic [CNT_W-1:0] chk_next;
    logic [CNT_W-1:0] err_next;
    logic [3:0]       cov_next;

    assign vec_ready = (state == ST_RUN);
    assign busy      = (state == ST_RUN) || (state == ST_WAIT);
    assign accept    = (state == ST_RUN) && vec_valid;
    assign sample    = (state == ST_WAIT) && (settle_cnt == 4'd0);
    assign mismatch  = sample && (dut_c != GATE_FUNC[vec_lat]);
    assign clear     = start && ((state == ST_IDLE) || (state == ST_DONE));

    // Next-cycle result values; the verdict on DONE entry must see this sample's effect
    always_comb begin
        chk_next = chk_cnt;
        err_next = err_cnt;
        cov_next = cov;
        if (sample) begin
            if (chk_cnt != CNT_MAX) chk_next = chk_cnt + 1'b1;
            cov_next = cov | (4'b0001 << vec_lat);
        end
        if (mismatch && (err_cnt != CNT_MAX)) begin
            err_next = err_cnt + 1'b1;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (vec_valid)  state_next = ST_WAIT;
                else if (stop)  state_next = ST_DONE;
            end
            ST_WAIT: begin
                if (sample) state_next = (stop_pend || stop) ? ST_DONE : ST_RUN;
            end
            ST_DONE: if (start) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    assign enter_done = (state_next == ST_DONE) && (state != ST_DONE);

    // State register, vector latch and settle countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            settle_cnt <= 4'd0;
            vec_lat    <= 2'b00;
        end else begin
            state <= state_next;
            if (accept) begin
                vec_lat    <= {vec_a, vec_b};
                settle_cnt <= SETTLE_LOAD;
            end else if ((state == ST_WAIT) && (settle_cnt != 4'd0)) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
        end
    end

    // Result accumulation, stop bookkeeping and verdict capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_cnt          <= '0;
            err_cnt          <= '0;
            cov              <= 4'h0;
            first_fail_vec   <= 2'b00;
            first_fail_valid <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            stop_pend        <= 1'b0;
        end else if (clear) begin
            chk_cnt          <= '0;
            err_cnt          <= '0;
            cov              <= 4'h0;
            first_fail_vec   <= 2'b00;
            first_fail_valid <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            stop_pend        <= 1'b0;
        end else begin
            chk_cnt <= chk_next;
            err_cnt <= err_next;
            cov     <= cov_next;
            if (mismatch && !first_fail_valid) begin
                first_fail_vec   <= vec_lat;
                first_fail_valid <= 1'b1;
            end
            if (enter_done) begin
                done      <= 1'b1;
                pass      <= (err_next == '0) && (cov_next == 4'hF);
                stop_pend <= 1'b0;
            end else if (stop && (accept || (state == ST_WAIT))) begin
                stop_pend <= 1'b1;
            end
        end
    end

endmodule
